// File: rtl/potential_accumulator.sv
// potential_accumulator: sums float32 synaptic weights onto one neuron's
// membrane potential per timestep, reports the result with a one-cycle
// pulse, then reloads from the decay stage before the next timestep.
// Optional build macro: POTENTIAL_FLOOR_EN clamps negative stored values to +0.0.
module potential_accumulator #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_en,
  input  logic [31:0]      init_potential,
  input  logic             decayed_valid,
  input  logic [31:0]      decayed_potential,
  input  logic             weight_valid,
  input  logic [31:0]      weight,
  output logic             weight_ready,
  input  logic             timestep_end,
  output logic [31:0]      new_potential,
  output logic             potential_valid,
  output logic             busy,
  output logic             exception_flag,
  output logic [CNT_W-1:0] weight_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  // Combinational float32 adder: {exception, sum}. Round to nearest even,
  // subnormal inputs/results flushed to zero; Inf/NaN operands or overflow
  // raise the exception bit.
  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [26:0] mb, ms, ms_al;
    logic [27:0] sum;
    logic [9:0]  shift, exp_r;
    logic [4:0]  lz;
    logic        found, sticky, rnd, zero;
    logic [24:0] mant;
    logic [22:0] frac;
    logic [32:0] res;
    big = 32'h0; sml = 32'h0; mb = 27'h0; ms = 27'h0; ms_al = 27'h0;
    sum = 28'h0; shift = 10'h0; exp_r = 10'h0; lz = 5'h0; found = 1'b0;
    sticky = 1'b0; rnd = 1'b0; zero = 1'b0; mant = 25'h0; frac = 23'h0;
    res = 33'h0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      res = {1'b1, 32'h0};
    end else begin
      // Order by magnitude so the result sign is the larger operand's sign.
      if (a[30:0] >= b[30:0]) begin
        big = a; sml = b;
      end else begin
        big = b; sml = a;
      end
      mb    = (big[30:23] == 8'h00) ? 27'h0 : {1'b1, big[22:0], 3'b000};
      ms    = (sml[30:23] == 8'h00) ? 27'h0 : {1'b1, sml[22:0], 3'b000};
      shift = {2'b00, big[30:23]} - {2'b00, sml[30:23]};
      if (shift > 10'd26) begin
        ms_al  = 27'h0;
        sticky = (ms != 27'h0);
      end else begin
        ms_al  = ms >> shift;
        sticky = ((ms & ((27'h1 << shift) - 27'h1)) != 27'h0);
      end
      ms_al[0] = ms_al[0] | sticky;
      if (big[31] == sml[31]) begin
        sum = {1'b0, mb} + {1'b0, ms_al};
      end else begin
        sum = {1'b0, mb} - {1'b0, ms_al};
      end
      exp_r = {2'b00, big[30:23]};
      zero  = (sum == 28'h0);
      if (!zero) begin
        if (sum[27]) begin
          sum   = {1'b0, sum[27:2], sum[1] | sum[0]};
          exp_r = exp_r + 10'd1;
        end else begin
          for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
              found = 1'b1;
              lz    = 5'(26 - i);
            end
          end
          if (exp_r <= {5'b00000, lz}) begin
            zero = 1'b1;
          end else begin
            sum   = sum << lz;
            exp_r = exp_r - {5'b00000, lz};
          end
        end
      end
      if (!zero) begin
        rnd  = sum[2] & (sum[1] | sum[0] | sum[3]);
        mant = {1'b0, sum[26:3]} + {24'h0, rnd};
        frac = mant[24] ? mant[23:1] : mant[22:0];
        exp_r = exp_r + {9'h0, mant[24]};
        if (exp_r >= 10'd255) begin
          res = {1'b1, 32'h0};
        end else begin
          res = {1'b0, big[31], exp_r[7:0], frac};
        end
      end else begin
        res = 33'h0;
      end
    end
    return res;
  endfunction

  // Resting-potential floor applied to every value stored from the adder or decay stage.
  function automatic logic [31:0] apply_floor(input logic [31:0] v);
`ifdef POTENTIAL_FLOOR_EN
    return v[31] ? 32'h0000_0000 : v;
`else
    return v;
`endif
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       accum_q, accum_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       new_potential_q, new_potential_d;
  logic              potential_valid_q, potential_valid_d;
  logic              busy_q, busy_d;
  logic              exc_q, exc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              fifo_empty, fifo_full, push, pop, ready;
  logic [31:0]       head;
  logic [32:0]       add_res;

  // FIFO status, weight handshake and the adder on the FIFO head.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = ((wr_ptr_q - rd_ptr_q) == DEPTH_CNT);
    ready      = 1'b0;
    if (init_en) begin
      ready = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: ready = !fifo_full;
        ST_WAIT:  ready = !fifo_full;
        default:  ready = 1'b0;
      endcase
    end
    push    = weight_valid && ready;
    pop     = !init_en && !fifo_empty && (state_q == ST_ACCUM || state_q == ST_FLUSH);
    head    = mem_q[rd_ptr_q[PTR_W-1:0]];
    add_res = fp_add(accum_q, head);
  end

  assign weight_ready = ready;

  // Next-state, accumulator, FIFO and output register computation.
  always_comb begin
    state_d           = state_q;
    accum_d           = accum_q;
    mem_d             = mem_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    new_potential_d   = new_potential_q;
    potential_valid_d = 1'b0;
    exc_d             = exc_q;
    cnt_d             = cnt_q;
    if (init_en) begin
      accum_d  = init_potential;
      wr_ptr_d = {(PTR_W+1){1'b0}};
      rd_ptr_d = {(PTR_W+1){1'b0}};
      cnt_d    = {CNT_W{1'b0}};
      exc_d    = 1'b0;
      state_d  = ST_ACCUM;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = weight;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (add_res[32]) begin
          exc_d = 1'b1;
        end else begin
          accum_d = apply_floor(add_res[31:0]);
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case (state_q)
        ST_ACCUM: begin
          if (timestep_end) state_d = ST_FLUSH;
          else              state_d = ST_ACCUM;
        end
        ST_FLUSH: begin
          if (fifo_empty) state_d = ST_DONE;
          else            state_d = ST_FLUSH;
        end
        ST_DONE: begin
          new_potential_d   = accum_q;
          potential_valid_d = 1'b1;
          state_d           = ST_WAIT;
        end
        ST_WAIT: begin
          if (decayed_valid) begin
            accum_d = apply_floor(decayed_potential);
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
    busy_d = (state_d == ST_FLUSH) || (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_ACCUM;
      accum_q           <= 32'h0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 32'h0;
      wr_ptr_q          <= {(PTR_W+1){1'b0}};
      rd_ptr_q          <= {(PTR_W+1){1'b0}};
      new_potential_q   <= 32'h0;
      potential_valid_q <= 1'b0;
      busy_q            <= 1'b0;
      exc_q             <= 1'b0;
      cnt_q             <= {CNT_W{1'b0}};
    end else begin
      state_q           <= state_d;
      accum_q           <= accum_d;
      mem_q             <= mem_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      new_potential_q   <= new_potential_d;
      potential_valid_q <= potential_valid_d;
      busy_q            <= busy_d;
      exc_q             <= exc_d;
      cnt_q             <= cnt_d;
    end
  end

  assign new_potential   = new_potential_q;
  assign potential_valid = potential_valid_q;
  assign busy            = busy_q;
  assign exception_flag  = exc_q;
  assign weight_count    = cnt_q;

endmodule

// File: tb/tb_potential_accumulator.sv
// Self-checking bench for potential_accumulator: directed scenarios plus
// randomized timesteps checked against a real-arithmetic reference model.
module tb_potential_accumulator;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, init_en, decayed_valid, weight_valid, timestep_end;
  logic [31:0]      init_potential, decayed_potential, weight;
  logic             weight_ready, potential_valid, busy, exception_flag;
  logic [31:0]      new_potential;
  logic [CNT_W-1:0] weight_count;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  potential_accumulator #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .init_en(init_en), .init_potential(init_potential),
    .decayed_valid(decayed_valid), .decayed_potential(decayed_potential),
    .weight_valid(weight_valid), .weight(weight), .weight_ready(weight_ready),
    .timestep_end(timestep_end), .new_potential(new_potential),
    .potential_valid(potential_valid), .busy(busy),
    .exception_flag(exception_flag), .weight_count(weight_count)
  );

  function automatic real floor_m(input real v);
`ifdef POTENTIAL_FLOOR_EN
    return (v < 0.0) ? 0.0 : v;
`else
    return v;
`endif
  endfunction

  // Exact real -> float32 encoding (values used here are always representable).
  function automatic logic [31:0] r2f(input real v);
    real m; int e; logic s; logic [22:0] frac;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    frac = 23'(longint'((m - 1.0) * 8388608.0));
    return {s, 8'(e), frac};
  endfunction

  function automatic real rand_half(input int k);
    return real'(int'($urandom_range(0, 2 * k)) - k) * 0.5;
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_init(input logic [31:0] v);
    init_en = 1'b1; init_potential = v; cycle(); init_en = 1'b0;
  endtask

  task automatic do_decay(input logic [31:0] v);
    decayed_valid = 1'b1; decayed_potential = v; cycle(); decayed_valid = 1'b0;
  endtask

  task automatic offer(input logic [31:0] w, output bit acc);
    weight_valid = 1'b1; weight = w;
    @(negedge clk); acc = weight_ready;
    cycle(); weight_valid = 1'b0;
  endtask

  // Strobe timestep_end, then count edges until the potential_valid pulse.
  task automatic end_ts(input int budget, output int lat);
    timestep_end = 1'b1; cycle(); timestep_end = 1'b0;
    lat = -1;
    for (int i = 1; i <= budget && lat < 0; i++) begin
      cycle();
      if (potential_valid === 1'b1) lat = i;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    total++; if (new_potential !== 32'h0) begin bad++; $display("FAIL reset_np: got %h want %h", new_potential, 32'h0); end
    total++; if (potential_valid !== 1'b0) begin bad++; $display("FAIL reset_pv: got %b want 0", potential_valid); end
    total++; if (weight_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", weight_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (exception_flag !== 1'b0) begin bad++; $display("FAIL reset_exc: got %b want 0", exception_flag); end
    total++; if (weight_count !== 8'h0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", weight_count); end
  endtask

  task automatic test_basic();
    bit a1, a2; int lat;
    do_init(32'h3F80_0000);
    offer(32'h4000_0000, a1);
    offer(32'h3F00_0000, a2);
    total++; if ({a1, a2} !== 2'b11) begin bad++; $display("FAIL basic_accept: got %b want 11", {a1, a2}); end
    end_ts(20, lat);
    total++; if (lat < 0) begin bad++; $display("FAIL basic_pulse: got timeout want pulse"); end
    total++; if (new_potential !== 32'h4060_0000) begin bad++; $display("FAIL basic_np: got %h want %h", new_potential, 32'h4060_0000); end
    total++; if (weight_count !== 8'd2) begin bad++; $display("FAIL basic_cnt: got %0d want 2", weight_count); end
    cycle();
    total++; if (potential_valid !== 1'b0) begin bad++; $display("FAIL basic_single_pulse: got %b want 0", potential_valid); end
  endtask

  task automatic test_back_to_back();
    bit acc, last; int n_acc; int lat;
    n_acc = 0; last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(32'h3F80_0000, acc);
      n_acc += int'(acc);
      last = acc;
    end
    total++; if (n_acc != 4) begin bad++; $display("FAIL bp_accepted: got %0d want 4", n_acc); end
    total++; if (last !== 1'b0) begin bad++; $display("FAIL bp_fifth_ready: got %b want 0", last); end
    do_decay(32'h41DE_D852);
    repeat (3) cycle();
    total++; if (weight_count !== 8'd3) begin bad++; $display("FAIL bp_drain3: got %0d want 3", weight_count); end
    cycle();
    total++; if (weight_count !== 8'd4) begin bad++; $display("FAIL bp_drain4: got %0d want 4", weight_count); end
    end_ts(20, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL bp_latency: got %0d want 2", lat); end
    total++; if (new_potential !== 32'h41FE_D852) begin bad++; $display("FAIL bp_np: got %h want %h", new_potential, 32'h41FE_D852); end
  endtask

  task automatic test_exception();
    bit acc; int lat;
    do_init(32'h3F80_0000);
    offer(32'h7F80_0000, acc);
    cycle(); cycle();
    total++; if (exception_flag !== 1'b1) begin bad++; $display("FAIL exc_flag: got %b want 1", exception_flag); end
    total++; if (weight_count !== 8'd0) begin bad++; $display("FAIL exc_cnt: got %0d want 0", weight_count); end
    end_ts(20, lat);
    total++; if (new_potential !== 32'h3F80_0000) begin bad++; $display("FAIL exc_np: got %h want %h", new_potential, 32'h3F80_0000); end
    total++; if (exception_flag !== 1'b1) begin bad++; $display("FAIL exc_sticky: got %b want 1", exception_flag); end
  endtask

  task automatic test_init_flush();
    bit acc; int n_acc; int lat; bit saw;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin offer(32'h3F80_0000, acc); n_acc += int'(acc); end
    total++; if (n_acc != 4) begin bad++; $display("FAIL if_fill: got %0d want 4", n_acc); end
    do_decay(32'h0);
    timestep_end = 1'b1; cycle(); timestep_end = 1'b0;
    cycle();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL if_busy_flush: got %b want 1", busy); end
    init_en = 1'b1; init_potential = 32'h4020_0000;
    weight_valid = 1'b1; weight = 32'h3F80_0000;
    @(negedge clk);
    total++; if (weight_ready !== 1'b0) begin bad++; $display("FAIL if_ready_init: got %b want 0", weight_ready); end
    cycle();
    init_en = 1'b0; weight_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL if_busy_after: got %b want 0", busy); end
    total++; if (exception_flag !== 1'b0) begin bad++; $display("FAIL if_exc_clear: got %b want 0", exception_flag); end
    total++; if (weight_count !== 8'd0) begin bad++; $display("FAIL if_cnt_clear: got %0d want 0", weight_count); end
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin cycle(); if (potential_valid === 1'b1) saw = 1'b1; end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL if_no_pulse: got %b want 0", saw); end
    end_ts(20, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL if_latency: got %0d want 2", lat); end
    total++; if (new_potential !== 32'h4020_0000) begin bad++; $display("FAIL if_np: got %h want %h", new_potential, 32'h4020_0000); end
  endtask

  task automatic test_negative();
    bit acc; int lat; logic [31:0] exp_np;
`ifdef POTENTIAL_FLOOR_EN
    exp_np = 32'h0000_0000;
`else
    exp_np = 32'hBF80_0000;
`endif
    do_init(32'h3F80_0000);
    offer(32'hC000_0000, acc);
    end_ts(20, lat);
    total++; if (new_potential !== exp_np) begin bad++; $display("FAIL neg_np: got %h want %h", new_potential, exp_np); end
  endtask

  task automatic test_saturation();
    bit acc; int n_acc; int lat;
    n_acc = 0;
    do_init(32'h0);
    for (int i = 0; i < 300; i++) begin offer(32'h3F80_0000, acc); n_acc += int'(acc); end
    total++; if (n_acc != 300) begin bad++; $display("FAIL sat_accept: got %0d want 300", n_acc); end
    end_ts(20, lat);
    total++; if (weight_count !== 8'hFF) begin bad++; $display("FAIL sat_cnt: got %0d want 255", weight_count); end
    total++; if (new_potential !== r2f(300.0)) begin bad++; $display("FAIL sat_np: got %h want %h", new_potential, r2f(300.0)); end
  endtask

  task automatic test_random();
    real acc_m, start, wv; int n_acc, n, tries, lat; bit acc;
    for (int it = 0; it < 10; it++) begin
      start = rand_half(40);
      if (it % 2 == 0) begin
        do_init(r2f(start));
        acc_m = start;
      end else begin
        timestep_end = 1'b1; cycle(); timestep_end = 1'b0;
        do_decay(r2f(start));
        acc_m = floor_m(start);
      end
      n_acc = 0;
      n = int'($urandom_range(1, 12));
      for (int k = 0; k < n; k++) begin
        wv = rand_half(40);
        acc = 1'b0; tries = 0;
        while (!acc && tries < 20) begin offer(r2f(wv), acc); tries++; end
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL rnd_accept it%0d: got timeout want accept", it); end
        if (acc) begin acc_m = floor_m(acc_m + wv); n_acc++; end
        if ($urandom_range(0, 3) == 0) begin
          decayed_valid = 1'b1; decayed_potential = r2f(rand_half(40)); cycle(); decayed_valid = 1'b0;
        end else begin
          repeat (int'($urandom_range(0, 2))) cycle();
        end
      end
      end_ts(40, lat);
      total++; if (lat < 0) begin bad++; $display("FAIL rnd_pulse it%0d: got timeout want pulse", it); end
      total++; if (new_potential !== r2f(acc_m)) begin bad++; $display("FAIL rnd_np it%0d: got %h want %h", it, new_potential, r2f(acc_m)); end
      total++; if (weight_count !== CNT_W'(n_acc)) begin bad++; $display("FAIL rnd_cnt it%0d: got %0d want %0d", it, weight_count, n_acc); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; init_en = 1'b0; decayed_valid = 1'b0; weight_valid = 1'b0;
    timestep_end = 1'b0; init_potential = 32'h0; decayed_potential = 32'h0; weight = 32'h0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_exception();
    test_init_flush();
    test_negative();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
